// File: rtl/packet_scheduler.sv
// packet_scheduler: picks the HDMI data-island packet for each packet slot.
// ACR has an anti-starvation override, then audio samples, then ACR, then the
// InfoFrames in round-robin order, then Null.
// Optional feature macro: PACKET_SCHEDULER_SPD_EN (SPD InfoFrame takes part in
// re-arm and round-robin; when undefined SPD is never pending).
module packet_scheduler #(
    parameter int INFOFRAME_PERIOD = 1,
    parameter int ACR_MAX_DEFER    = 4
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       packet_slot,
    input  logic       frame_start,
    input  logic       acr_wrap,
    input  logic       sample_ready,
    output logic [7:0] packet_type,
    output logic       packet_valid,
    output logic       sample_ack,
    output logic       acr_overrun
);

    typedef enum logic [2:0] {
        SEL_NULL, SEL_ACR, SEL_SAMPLE, SEL_AVI, SEL_AIF, SEL_SPD
    } sel_t;

    localparam logic [1:0] RR_AVI = 2'd0;
    localparam logic [1:0] RR_AIF = 2'd1;
`ifdef PACKET_SCHEDULER_SPD_EN
    localparam logic [1:0] RR_AFTER_AIF = 2'd2;
`else
    localparam logic [1:0] RR_AFTER_AIF = RR_AVI;
`endif
    localparam logic [3:0] DEFER_MAX    = 4'(ACR_MAX_DEFER);
    localparam logic [7:0] FRAME_LAST   = 8'(INFOFRAME_PERIOD - 1);

    logic       r_acr_prev;
    logic       r_acr_pending;
    logic       r_acr_overrun;
    logic [7:0] r_frame_cnt;
    logic       r_avi_pending;
    logic       r_aif_pending;
    logic [1:0] r_rr_ptr;
    logic [3:0] r_defer;
    logic [7:0] r_packet_type;
    logic       r_packet_valid;
    logic       r_sample_ack;

    logic       w_acr_edge;
    logic       w_rearm;
    logic       w_spd_pending;
    sel_t       w_if_sel;
    sel_t       w_sel;
    logic [7:0] w_hb0;
    logic       w_take_acr;
    logic       w_take_avi;
    logic       w_take_aif;

    assign w_acr_edge = acr_wrap ^ r_acr_prev;
    assign w_rearm    = frame_start && (r_frame_cnt == 8'd0);
    assign w_take_acr = packet_slot && (w_sel == SEL_ACR);
    assign w_take_avi = packet_slot && (w_sel == SEL_AVI);
    assign w_take_aif = packet_slot && (w_sel == SEL_AIF);

`ifdef PACKET_SCHEDULER_SPD_EN
    logic r_spd_pending;
    logic w_take_spd;
    assign w_take_spd    = packet_slot && (w_sel == SEL_SPD);
    assign w_spd_pending = r_spd_pending;

    // SPD pending flag: re-arm wins over consumption in the same cycle
    always_ff @(posedge clk_pixel) begin
        if (reset) r_spd_pending <= 1'b0;
        else       r_spd_pending <= w_rearm | (r_spd_pending & ~w_take_spd);
    end
`else
    assign w_spd_pending = 1'b0;
`endif

    // Round-robin InfoFrame search starting at the pointer
    always_comb begin
        w_if_sel = SEL_NULL;
        case (r_rr_ptr)
            RR_AVI: begin
                if (r_avi_pending)      w_if_sel = SEL_AVI;
                else if (r_aif_pending) w_if_sel = SEL_AIF;
                else if (w_spd_pending) w_if_sel = SEL_SPD;
            end
            RR_AIF: begin
                if (r_aif_pending)      w_if_sel = SEL_AIF;
                else if (w_spd_pending) w_if_sel = SEL_SPD;
                else if (r_avi_pending) w_if_sel = SEL_AVI;
            end
            default: begin
                if (w_spd_pending)      w_if_sel = SEL_SPD;
                else if (r_avi_pending) w_if_sel = SEL_AVI;
                else if (r_aif_pending) w_if_sel = SEL_AIF;
            end
        endcase
    end

    // Fixed-priority decision and HB0 lookup for the current slot
    always_comb begin
        w_sel = SEL_NULL;
        if (r_acr_pending && (r_defer == DEFER_MAX)) w_sel = SEL_ACR;
        else if (sample_ready)                      w_sel = SEL_SAMPLE;
        else if (r_acr_pending)                     w_sel = SEL_ACR;
        else                                        w_sel = w_if_sel;

        w_hb0 = 8'h00;
        case (w_sel)
            SEL_ACR:    w_hb0 = 8'h01;
            SEL_SAMPLE: w_hb0 = 8'h02;
            SEL_AVI:    w_hb0 = 8'h82;
            SEL_AIF:    w_hb0 = 8'h84;
            SEL_SPD:    w_hb0 = 8'h83;
            default:    w_hb0 = 8'h00;
        endcase
    end

    // ACR toggle edge detect, pending flag and sticky overrun
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_acr_prev    <= acr_wrap;
            r_acr_pending <= 1'b0;
            r_acr_overrun <= 1'b0;
        end else begin
            r_acr_prev    <= acr_wrap;
            r_acr_pending <= w_acr_edge | (r_acr_pending & ~w_take_acr);
            if (w_acr_edge && r_acr_pending && !w_take_acr)
                r_acr_overrun <= 1'b1;
        end
    end

    // Frame counter and AVI/Audio InfoFrame pending flags
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_frame_cnt   <= 8'd0;
            r_avi_pending <= 1'b0;
            r_aif_pending <= 1'b0;
        end else begin
            if (frame_start)
                r_frame_cnt <= (r_frame_cnt == FRAME_LAST) ? 8'd0 : r_frame_cnt + 8'd1;
            r_avi_pending <= w_rearm | (r_avi_pending & ~w_take_avi);
            r_aif_pending <= w_rearm | (r_aif_pending & ~w_take_aif);
        end
    end

    // Registered slot outputs, round-robin pointer and ACR defer counter
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_packet_type  <= 8'h00;
            r_packet_valid <= 1'b0;
            r_sample_ack   <= 1'b0;
            r_rr_ptr       <= RR_AVI;
            r_defer        <= 4'd0;
        end else begin
            r_packet_valid <= packet_slot;
            r_sample_ack   <= packet_slot && (w_sel == SEL_SAMPLE);
            if (packet_slot) begin
                r_packet_type <= w_hb0;
                case (w_sel)
                    SEL_AVI: r_rr_ptr <= RR_AIF;
                    SEL_AIF: r_rr_ptr <= RR_AFTER_AIF;
                    SEL_SPD: r_rr_ptr <= RR_AVI;
                    default: r_rr_ptr <= r_rr_ptr;
                endcase
                if (w_sel == SEL_ACR)
                    r_defer <= 4'd0;
                else if (r_acr_pending && (r_defer != DEFER_MAX))
                    r_defer <= r_defer + 4'd1;
            end
        end
    end

    assign packet_type  = r_packet_type;
    assign packet_valid = r_packet_valid;
    assign sample_ack   = r_sample_ack;
    assign acr_overrun  = r_acr_overrun;

endmodule

// File: tb/tb_packet_scheduler.sv
// Testbench for packet_scheduler: directed scenarios plus a randomized run
// checked against a slot-level reference model.
module tb_packet_scheduler;

    localparam int P_PERIOD = 3;
    localparam int P_DEFER  = 4;
`ifdef PACKET_SCHEDULER_SPD_EN
    localparam bit SPD_EN = 1'b1;
`else
    localparam bit SPD_EN = 1'b0;
`endif

    logic       clk_pixel    = 1'b0;
    logic       reset        = 1'b1;
    logic       packet_slot  = 1'b0;
    logic       frame_start  = 1'b0;
    logic       acr_wrap     = 1'b0;
    logic       sample_ready = 1'b0;
    logic [7:0] packet_type;
    logic       packet_valid;
    logic       sample_ack;
    logic       acr_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit         m_prev     = 1'b0;
    bit         m_acr_pend = 1'b0;
    bit         m_ovr      = 1'b0;
    int         m_fcnt     = 0;
    int         m_rr       = 0;
    int         m_defer    = 0;
    bit         m_if_pend [3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] m_type     = 8'h00;
    bit         m_valid    = 1'b0;
    bit         m_ack      = 1'b0;
    logic [7:0] if_hb [3]  = '{8'h82, 8'h84, 8'h83};
    logic [7:0] exp_if [4];

    packet_scheduler #(
        .INFOFRAME_PERIOD (P_PERIOD),
        .ACR_MAX_DEFER    (P_DEFER)
    ) dut (
        .clk_pixel    (clk_pixel),
        .reset        (reset),
        .packet_slot  (packet_slot),
        .frame_start  (frame_start),
        .acr_wrap     (acr_wrap),
        .sample_ready (sample_ready),
        .packet_type  (packet_type),
        .packet_valid (packet_valid),
        .sample_ack   (sample_ack),
        .acr_overrun  (acr_overrun)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Advances the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        int n;
        int pick;
        bit edge_ev;
        bit rearm;
        bit take_acr;
        n = SPD_EN ? 3 : 2;
        if (reset) begin
            m_prev = acr_wrap; m_acr_pend = 0; m_ovr = 0; m_fcnt = 0; m_rr = 0;
            m_defer = 0; m_if_pend = '{1'b0, 1'b0, 1'b0};
            m_type = 8'h00; m_valid = 0; m_ack = 0;
            return;
        end
        edge_ev = (acr_wrap != m_prev);
        m_prev  = acr_wrap;
        rearm   = frame_start && (m_fcnt == 0);
        if (frame_start) m_fcnt = (m_fcnt + 1) % P_PERIOD;
        m_valid  = packet_slot;
        m_ack    = 0;
        take_acr = 0;
        pick     = -1;
        if (packet_slot) begin
            if (m_acr_pend && m_defer == P_DEFER) take_acr = 1;
            else if (sample_ready)                m_ack = 1;
            else if (m_acr_pend)                  take_acr = 1;
            else
                for (int k = 0; k < n; k++)
                    if (pick < 0 && m_if_pend[(m_rr + k) % n]) pick = (m_rr + k) % n;
            if (take_acr)     m_type = 8'h01;
            else if (m_ack)   m_type = 8'h02;
            else if (pick >= 0) m_type = if_hb[pick];
            else              m_type = 8'h00;
            if (take_acr) m_defer = 0;
            else if (m_acr_pend && m_defer < P_DEFER) m_defer = m_defer + 1;
            if (take_acr) m_acr_pend = 0;
            if (pick >= 0) begin
                m_if_pend[pick] = 0;
                m_rr = (pick + 1) % n;
            end
        end
        if (edge_ev) begin
            if (m_acr_pend) m_ovr = 1;
            m_acr_pend = 1;
        end
        if (rearm) begin
            m_if_pend[0] = 1; m_if_pend[1] = 1; m_if_pend[2] = SPD_EN;
        end
    endtask

    // Drives one clock of inputs, then returns 1 time unit after the edge.
    task automatic cycle(input bit slot, input bit fs, input bit tog, input bit sr, input bit rst);
        packet_slot  = slot;
        frame_start  = fs;
        sample_ready = sr;
        reset        = rst;
        if (tog) acr_wrap = ~acr_wrap;
        model_step();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_reset();
        acr_wrap = 1'b1;
        do_reset();
        n_checks++; if (packet_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", packet_valid); end
        n_checks++; if (packet_type !== 8'h00) begin n_fail++; $display("FAIL reset_type got %h want 00", packet_type); end
        n_checks++; if (sample_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %0b want 0", sample_ack); end
        n_checks++; if (acr_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got %0b want 0", acr_overrun); end
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0, 0);
            n_checks++;
            if (packet_valid !== 1'b1 || packet_type !== 8'h00) begin
                n_fail++; $display("FAIL reset_null_slot%0d got v=%0b t=%h want v=1 t=00", i, packet_valid, packet_type);
            end
            cycle(0, 0, 0, 0, 0);
            n_checks++;
            if (packet_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_pulse got %0b want 0", packet_valid); end
        end
        n_checks++; if (acr_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr_after got %0b want 0", acr_overrun); end
    endtask

    task automatic test_acr();
        do_reset();
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        n_checks++;
        if (packet_valid !== 1'b1 || packet_type !== 8'h01 || sample_ack !== 1'b0) begin
            n_fail++; $display("FAIL acr_slot got v=%0b t=%h a=%0b want v=1 t=01 a=0", packet_valid, packet_type, sample_ack);
        end
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        n_checks++;
        if (packet_type !== 8'h00) begin n_fail++; $display("FAIL acr_next_null got %h want 00", packet_type); end
    endtask

    task automatic test_infoframe();
        do_reset();
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 0, 0);
            n_checks++;
            if (packet_valid !== 1'b1 || packet_type !== exp_if[i] || sample_ack !== 1'b0) begin
                n_fail++; $display("FAIL infoframe_slot%0d got t=%h a=%0b want t=%h a=0", i, packet_type, sample_ack, exp_if[i]);
            end
            cycle(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_defer();
        logic [7:0] want;
        do_reset();
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            want = (i == 4) ? 8'h01 : 8'h02;
            cycle(1, 0, 0, 1, 0);
            n_checks++;
            if (packet_type !== want || sample_ack !== (i != 4)) begin
                n_fail++; $display("FAIL defer_slot%0d got t=%h a=%0b want t=%h a=%0b", i, packet_type, sample_ack, want, (i != 4));
            end
            cycle(0, 0, 0, 1, 0);
            n_checks++;
            if (sample_ack !== 1'b0) begin n_fail++; $display("FAIL defer_ack_pulse%0d got %0b want 0", i, sample_ack); end
        end
        cycle(0, 0, 0, 0, 0);
    endtask

    task automatic test_overrun();
        do_reset();
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0);
        n_checks++;
        if (packet_type !== 8'h01 || acr_overrun !== 1'b0) begin
            n_fail++; $display("FAIL ovr_consume_edge got t=%h o=%0b want t=01 o=0", packet_type, acr_overrun);
        end
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        n_checks++;
        if (packet_type !== 8'h01 || acr_overrun !== 1'b0) begin
            n_fail++; $display("FAIL ovr_set_wins got t=%h o=%0b want t=01 o=0", packet_type, acr_overrun);
        end
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        n_checks++;
        if (packet_type !== 8'h00) begin n_fail++; $display("FAIL ovr_drained got %h want 00", packet_type); end
        cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0, 0);
        n_checks++;
        if (acr_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early got %0b want 0", acr_overrun); end
        cycle(0, 0, 1, 0, 0);
        n_checks++;
        if (acr_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %0b want 1", acr_overrun); end
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        n_checks++;
        if (packet_type !== 8'h01 || acr_overrun !== 1'b1) begin
            n_fail++; $display("FAIL ovr_sticky got t=%h o=%0b want t=01 o=1", packet_type, acr_overrun);
        end
    endtask

    task automatic test_period();
        logic [7:0] want;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            cycle(0, 1, 0, 0, 0);
            for (int s = 0; s < 4; s++) begin
                want = (f % P_PERIOD == 0) ? exp_if[s] : 8'h00;
                cycle(1, 0, 0, 0, 0);
                n_checks++;
                if (packet_type !== want) begin
                    n_fail++; $display("FAIL period_f%0d_s%0d got %h want %h", f, s, packet_type, want);
                end
                cycle(0, 0, 0, 0, 0);
            end
        end
        do_reset();
        cycle(0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        n_checks++;
        if (packet_type !== 8'h82) begin n_fail++; $display("FAIL midreset_f0 got %h want 82", packet_type); end
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        do_reset();
        for (int s = 0; s < 3; s++) begin
            cycle(1, 0, 0, 0, 0);
            n_checks++;
            if (packet_type !== 8'h00) begin n_fail++; $display("FAIL midreset_discard%0d got %h want 00", s, packet_type); end
            cycle(0, 0, 0, 0, 0);
        end
        cycle(0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        n_checks++;
        if (packet_type !== 8'h82) begin n_fail++; $display("FAIL midreset_rearm got %h want 82", packet_type); end
    endtask

    task automatic test_random();
        bit src_sr;
        bit slot, fs, tog, rst;
        src_sr = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            slot = ($urandom_range(0, 2) == 0);
            fs   = ($urandom_range(0, 59) == 0);
            tog  = ($urandom_range(0, 24) == 0);
            rst  = ($urandom_range(0, 999) == 0);
            if (!src_sr && $urandom_range(0, 3) == 0) src_sr = 1;
            cycle(slot, fs, tog, src_sr, rst);
            if (rst) src_sr = 0;
            n_checks++;
            if (packet_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid cyc%0d got %0b want %0b", i, packet_valid, m_valid); end
            n_checks++;
            if (packet_type !== m_type) begin n_fail++; $display("FAIL rand_type cyc%0d got %h want %h", i, packet_type, m_type); end
            n_checks++;
            if (sample_ack !== m_ack) begin n_fail++; $display("FAIL rand_ack cyc%0d got %0b want %0b", i, sample_ack, m_ack); end
            n_checks++;
            if (acr_overrun !== m_ovr) begin n_fail++; $display("FAIL rand_ovr cyc%0d got %0b want %0b", i, acr_overrun, m_ovr); end
            if (m_ack) src_sr = 0;
        end
    endtask

    initial begin
        exp_if[0] = 8'h82;
        exp_if[1] = 8'h84;
        exp_if[2] = SPD_EN ? 8'h83 : 8'h00;
        exp_if[3] = 8'h00;
        test_reset();
        test_acr();
        test_infoframe();
        test_defer();
        test_overrun();
        test_period();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
